// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM
// states and parameter legality check.
package muldiv_pkg;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

  localparam int unsigned MD_RV_NARROW = 16;
  localparam int unsigned MD_RV_WIDE   = 32;
  localparam int unsigned MD_STEP_MAX  = 4;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_RUN   = 2'd1,
    MD_FIXUP = 2'd2,
    MD_DONE  = 2'd3
  } md_state_e;

  // True when the width/radix pair is a supported configuration.
  function automatic bit md_params_legal(input int unsigned rv, input int unsigned step);
    return ((rv == MD_RV_NARROW) || (rv == MD_RV_WIDE)) &&
           ((step == 1) || (step == 2) || (step == MD_STEP_MAX)) &&
           ((rv % step) == 0);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the execute stage and muldiv_unit.
interface muldiv_if #(
  parameter int unsigned RV = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic          req_signed;
  logic [RV-1:0] req_a;
  logic [RV-1:0] req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RV-1:0] rsp_lo;
  logic [RV-1:0] rsp_hi;
  logic          rsp_div0;

  modport master (
    output req_valid, req_op, req_signed, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_div0
  );

  modport slave (
    input  req_valid, req_op, req_signed, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_div0
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 step: shift-add for multiply, restoring subtract for divide.
// The accumulator is {high word, low word}; divide keeps remainder high, quotient low.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned RV = 32
) (
  input  logic            op_i,
  input  logic [2*RV-1:0] acc_i,
  input  logic [RV-1:0]   b_i,
  input  logic            abit_i,
  output logic [2*RV-1:0] acc_o
);

  logic [2*RV:0] shifted;
  logic [RV:0]   top;
  logic [RV-1:0] diff;

  always_comb begin
    shifted = {acc_i, 1'b0};
    top     = shifted[2*RV:RV];
    diff    = top[RV-1:0] - b_i;
    acc_o   = shifted[2*RV-1:0];
    if (op_i == MD_OP_MUL) begin
      acc_o = shifted[2*RV-1:0] + (abit_i ? {RV'(0), b_i} : (2*RV)'(0));
    end else if (top >= {1'b0, b_i}) begin
      // Trial subtraction succeeds: keep the difference, shift in a 1.
      acc_o = {diff, shifted[RV-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit, STEP result bits per cycle.
// Signed operation is built only when MULDIV_SIGNED_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned RV   = 32,
  parameter int unsigned STEP = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     abort,
  muldiv_if.slave  bus,
  output logic     busy
);

  localparam int unsigned NITER = RV / STEP;
  localparam int unsigned CW    = (NITER > 1) ? $clog2(NITER) : 1;

  if (!md_params_legal(RV, STEP)) begin : g_bad_params
    $error("muldiv_unit: unsupported RV/STEP combination");
  end

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*RV-1:0] acc_q, acc_d;
  logic [RV-1:0]   a_q, a_d;
  logic [RV-1:0]   b_q, b_d;
  logic            op_q, op_d;
  logic            div0_q, div0_d;
  logic            fixup_q, fixup_d;
  logic            neg_lo_q, neg_lo_d;
  logic            neg_hi_q, neg_hi_d;

  logic            accept_c;
  logic            sa_c, sb_c, sgn_c;
  logic [RV-1:0]   mag_a_c, mag_b_c;
  logic [2*RV-1:0] chain_c [STEP+1];

  // Operand magnitudes and sign flags captured at accept.
`ifdef MULDIV_SIGNED_EN
  always_comb begin
    sgn_c   = bus.req_signed;
    sa_c    = bus.req_signed & bus.req_a[RV-1];
    sb_c    = bus.req_signed & bus.req_b[RV-1];
    mag_a_c = sa_c ? (RV'(0) - bus.req_a) : bus.req_a;
    mag_b_c = sb_c ? (RV'(0) - bus.req_b) : bus.req_b;
  end
`else
  logic unused_req_signed;
  assign unused_req_signed = bus.req_signed;
  assign sgn_c   = 1'b0;
  assign sa_c    = 1'b0;
  assign sb_c    = 1'b0;
  assign mag_a_c = bus.req_a;
  assign mag_b_c = bus.req_b;
`endif

  assign chain_c[0] = acc_q;

  for (genvar g = 0; g < STEP; g++) begin : g_step
    muldiv_step #(.RV(RV)) u_step (
      .op_i   (op_q),
      .acc_i  (chain_c[g]),
      .b_i    (b_q),
      .abit_i (a_q[RV-1-g]),
      .acc_o  (chain_c[g+1])
    );
  end

  assign bus.req_ready = (state_q == MD_IDLE) && !reset;
  assign accept_c      = bus.req_valid && bus.req_ready && !abort;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    div0_d   = div0_q;
    fixup_d  = fixup_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;

    case (state_q)
      MD_IDLE: begin
        if (accept_c) begin
          op_d     = bus.req_op;
          div0_d   = 1'b0;
          cnt_d    = CW'(NITER - 1);
          a_d      = mag_a_c;
          b_d      = mag_b_c;
          fixup_d  = sgn_c;
          neg_lo_d = sa_c ^ sb_c;
          neg_hi_d = (bus.req_op == MD_OP_DIV) ? sa_c : (sa_c ^ sb_c);
          if ((bus.req_op == MD_OP_DIV) && (bus.req_b == '0)) begin
            acc_d   = {bus.req_a, RV'(0)};
            div0_d  = 1'b1;
            fixup_d = 1'b0;
            state_d = MD_DONE;
          end else begin
            acc_d   = (bus.req_op == MD_OP_DIV) ? {RV'(0), mag_a_c} : (2*RV)'(0);
            state_d = MD_RUN;
          end
        end
      end
      MD_RUN: begin
        acc_d = chain_c[STEP];
        a_d   = a_q << STEP;
        if (cnt_q == '0) begin
          state_d = fixup_q ? MD_FIXUP : MD_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      MD_FIXUP: begin
        // Product negates as one 2RV value; quotient and remainder separately.
        state_d = MD_DONE;
        if (op_q == MD_OP_MUL) begin
          if (neg_lo_q) acc_d = (2*RV)'(0) - acc_q;
        end else begin
          acc_d = {neg_hi_q ? (RV'(0) - acc_q[2*RV-1:RV]) : acc_q[2*RV-1:RV],
                   neg_lo_q ? (RV'(0) - acc_q[RV-1:0])    : acc_q[RV-1:0]};
        end
      end
      MD_DONE: begin
        if (bus.rsp_ready) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase

    if (abort) state_d = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= MD_OP_MUL;
      div0_q   <= 1'b0;
      fixup_q  <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      div0_q   <= div0_d;
      fixup_q  <= fixup_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

  assign bus.rsp_valid = (state_q == MD_DONE);
  assign bus.rsp_lo    = acc_q[RV-1:0];
  assign bus.rsp_hi    = acc_q[2*RV-1:RV];
  assign bus.rsp_div0  = div0_q;
  assign busy          = (state_q != MD_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: RV=16/STEP=1 and RV=32/STEP=4 instances.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  logic abort;
  logic busy16, busy32;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_if #(.RV(16)) bus16 ();
  muldiv_if #(.RV(32)) bus32 ();

  muldiv_unit #(.RV(16), .STEP(1)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .abort (abort),
    .bus   (bus16),
    .busy  (busy16)
  );

  muldiv_unit #(.RV(32), .STEP(4)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .abort (abort),
    .bus   (bus32),
    .busy  (busy32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 16-bit transaction: accept, measure latency, check result, optional handshake.
  task automatic run16(input string tag, input logic op, input logic sgn,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_lo, input logic [15:0] exp_hi,
                       input logic exp_div0, input int exp_lat, input bit hs);
    int n_wait;
    int lat;
    n_wait = 0;
    while (!bus16.req_ready && n_wait < 50) begin
      tick();
      n_wait++;
    end
    check({tag, "_ready"}, 64'(bus16.req_ready), 64'(1));
    bus16.req_valid  = 1'b1;
    bus16.req_op     = op;
    bus16.req_signed = sgn;
    bus16.req_a      = a;
    bus16.req_b      = b;
    tick();
    bus16.req_valid  = 1'b0;
    lat = 1;
    while (!bus16.rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_lat"},  64'(lat),            64'(exp_lat));
    check({tag, "_lo"},   64'(bus16.rsp_lo),   64'(exp_lo));
    check({tag, "_hi"},   64'(bus16.rsp_hi),   64'(exp_hi));
    check({tag, "_div0"}, 64'(bus16.rsp_div0), 64'(exp_div0));
    if (hs) begin
      bus16.rsp_ready = 1'b1;
      tick();
      bus16.rsp_ready = 1'b0;
      check({tag, "_released"}, 64'(bus16.rsp_valid), 64'(0));
    end
  endtask

  initial begin
    int lat;
    int n_wait;

    reset            = 1'b1;
    abort            = 1'b0;
    bus16.req_valid  = 1'b0;
    bus16.req_op     = 1'b0;
    bus16.req_signed = 1'b0;
    bus16.req_a      = '0;
    bus16.req_b      = '0;
    bus16.rsp_ready  = 1'b0;
    bus32.req_valid  = 1'b0;
    bus32.req_op     = 1'b0;
    bus32.req_signed = 1'b0;
    bus32.req_a      = '0;
    bus32.req_b      = '0;
    bus32.rsp_ready  = 1'b0;

    repeat (3) tick();
    check("rst_ready", 64'(bus16.req_ready), 64'(0));
    check("rst_valid", 64'(bus16.rsp_valid), 64'(0));
    check("rst_busy",  64'(busy16),          64'(0));
    check("rst_lo",    64'(bus16.rsp_lo),    64'(0));
    check("rst_hi",    64'(bus16.rsp_hi),    64'(0));
    check("rst_div0",  64'(bus16.rsp_div0),  64'(0));
    reset = 1'b0;
    tick();
    check("post_rst_ready", 64'(bus16.req_ready), 64'(1));

    // 0x1234 * 0x5678 = 0x0626_0060
    run16("mul_a", 1'b0, 1'b0, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 1'b0, 17, 1'b1);
    run16("mul_zero", 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17, 1'b1);
    // 0xFFFF * 0xFFFF = 0xFFFE_0001
    run16("mul_max", 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17, 1'b1);
    // 0xFFFF / 0x10 = 0x0FFF rem 0xF
    run16("div_a", 1'b1, 1'b0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0, 17, 1'b1);
    run16("div_small", 1'b1, 1'b0, 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 17, 1'b1);
    run16("div0", 1'b1, 1'b0, 16'hDEAD, 16'h0000, 16'h0000, 16'hDEAD, 1'b1, 1, 1'b1);

    // Abort three cycles into a multiply while a new request is offered.
    bus16.req_valid = 1'b1;
    bus16.req_op    = 1'b0;
    bus16.req_a     = 16'h1111;
    bus16.req_b     = 16'h2222;
    tick();
    check("abort_busy_run", 64'(busy16), 64'(1));
    tick();
    tick();
    bus16.req_a = 16'd3;
    bus16.req_b = 16'd5;
    abort       = 1'b1;
    tick();
    abort           = 1'b0;
    bus16.req_valid = 1'b0;
    check("abort_busy",  64'(busy16),          64'(0));
    check("abort_valid", 64'(bus16.rsp_valid), 64'(0));
    tick();
    check("abort_no_accept", 64'(busy16), 64'(0));
    run16("mul_after_abort", 1'b0, 1'b0, 16'd3, 16'd5, 16'd15, 16'd0, 1'b0, 17, 1'b1);

    // RV=32, STEP=4: 100 / 7 with a stalled consumer.
    n_wait = 0;
    while (!bus32.req_ready && n_wait < 50) begin
      tick();
      n_wait++;
    end
    bus32.req_valid = 1'b1;
    bus32.req_op    = 1'b1;
    bus32.req_a     = 32'd100;
    bus32.req_b     = 32'd7;
    tick();
    bus32.req_valid = 1'b0;
    lat = 1;
    while (!bus32.rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("div32_lat",  64'(lat),            64'(9));
    check("div32_lo",   64'(bus32.rsp_lo),   64'(14));
    check("div32_hi",   64'(bus32.rsp_hi),   64'(2));
    check("div32_div0", 64'(bus32.rsp_div0), 64'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("div32_hold_valid", 64'(bus32.rsp_valid), 64'(1));
      check("div32_hold_lo",    64'(bus32.rsp_lo),    64'(14));
      check("div32_hold_hi",    64'(bus32.rsp_hi),    64'(2));
      check("div32_hold_ready", 64'(bus32.req_ready), 64'(0));
    end
    bus32.rsp_ready = 1'b1;
    tick();
    bus32.rsp_ready = 1'b0;
    check("div32_released", 64'(bus32.rsp_valid), 64'(0));
    check("div32_idle",     64'(busy32),          64'(0));

`ifdef MULDIV_SIGNED_EN
    run16("sdiv_neg7_2", 1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 18, 1'b1);
    run16("sdiv_min_m1", 1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 18, 1'b1);
    run16("smul_m3_4",   1'b0, 1'b1, 16'hFFFD, 16'h0004, 16'hFFF4, 16'hFFFF, 1'b0, 18, 1'b1);
`else
    // req_signed is ignored: 0xFFFD * 4 = 0x0003_FFF4 unsigned.
    run16("umul_sgn_ignored", 1'b0, 1'b1, 16'hFFFD, 16'h0004, 16'hFFF4, 16'h0003, 1'b0, 17, 1'b1);
`endif

    // Reset while a divide-by-zero result is held in DONE.
    run16("div0_hold", 1'b1, 1'b0, 16'hDEAD, 16'h0000, 16'h0000, 16'hDEAD, 1'b1, 1, 1'b0);
    reset = 1'b1;
    tick();
    check("rst_done_ready", 64'(bus16.req_ready), 64'(0));
    check("rst_done_valid", 64'(bus16.rsp_valid), 64'(0));
    check("rst_done_busy",  64'(busy16),          64'(0));
    check("rst_done_lo",    64'(bus16.rsp_lo),    64'(0));
    check("rst_done_hi",    64'(bus16.rsp_hi),    64'(0));
    check("rst_done_div0",  64'(bus16.rsp_div0),  64'(0));
    reset = 1'b0;
    tick();
    check("rst_done_ready_after", 64'(bus16.req_ready), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
